// File: rtl/button_event_generator_pkg.sv
// Shared definitions for the button event generator.
// Contents:
//   - Per-button FSM state encodings.
//   - Default timing constants for the 25 MHz board clock.
//   - A helper used to size the hold counter.
package button_event_generator_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  localparam int DEF_CLKS_PER_MS      = 25000;
  localparam int DEF_LONG_PRESS_MS    = 800;
  localparam int DEF_REPEAT_PERIOD_MS = 200;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_generator_fsm.sv
// Single-button event FSM.
// Turns one clean level into registered one-cycle press, release,
// long-press and auto-repeat pulses, plus a held level.
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_level    debounced button level, 1 = pressed
//   i_ms_tick  one-cycle millisecond strobe from the shared prescaler
//   o_press    pulse one cycle after the level rises
//   o_release  pulse one cycle after the level falls (not on reset)
//   o_long     pulse when the hold reaches LONG_PRESS_MS
//   o_repeat   pulse every REPEAT_PERIOD_MS after o_long while held
//   o_held     level, 1 while the FSM is not IDLE
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | button up, waiting for a press
// ST_PRESSED | button down, counting ms toward the long-press
// ST_HELD    | long-press reached, counting ms toward each repeat
module button_event_fsm
  import button_event_generator_pkg::*;
#(
  parameter int LONG_PRESS_MS    = DEF_LONG_PRESS_MS,
  parameter int REPEAT_PERIOD_MS = DEF_REPEAT_PERIOD_MS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  input  logic i_ms_tick,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int CNT_W = $clog2(max_int(LONG_PRESS_MS, REPEAT_PERIOD_MS) + 1);
  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_PRESS_MS);
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_PERIOD_MS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + 1'b1;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_level) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        // Release is checked first so it wins over a coincident threshold tick.
        if (!i_level) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (i_ms_tick) begin
          if (cnt_inc == LONG_C) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_HELD: begin
        if (!i_level) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (i_ms_tick) begin
          if (cnt_inc == REPEAT_C) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_held    = (state_q != ST_IDLE);

endmodule

// File: rtl/button_event_generator.sv
// Four-button event generator.
// Converts debounced button levels into press/release/long/repeat pulses
// and held levels. One millisecond prescaler is shared by all buttons, so
// every button's timing is quantised to the same tick phase.
// Ports:
//   i_Clk      system clock
//   i_Reset    asynchronous active-high reset
//   i_Buttons  debounced levels, 1 = pressed, already in i_Clk domain
//   o_Press    per-button one-cycle press pulse
//   o_Release  per-button one-cycle release pulse
//   o_Long     per-button one-cycle long-press pulse
//   o_Repeat   per-button one-cycle auto-repeat pulse
//   o_Held     per-button level, 1 while the button FSM is not IDLE
module button_event_generator
  import button_event_generator_pkg::*;
#(
  parameter int CLKS_PER_MS      = DEF_CLKS_PER_MS,
  parameter int LONG_PRESS_MS    = DEF_LONG_PRESS_MS,
  parameter int REPEAT_PERIOD_MS = DEF_REPEAT_PERIOD_MS
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Buttons,
  output logic [3:0] o_Press,
  output logic [3:0] o_Release,
  output logic [3:0] o_Long,
  output logic [3:0] o_Repeat,
  output logic [3:0] o_Held
);

  localparam int PRE_W = $clog2(CLKS_PER_MS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_MS - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             ms_tick;

  assign ms_tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q + 1'b1;
    if (ms_tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_event_fsm #(
      .LONG_PRESS_MS    (LONG_PRESS_MS),
      .REPEAT_PERIOD_MS (REPEAT_PERIOD_MS)
    ) u_fsm (
      .i_clk     (i_Clk),
      .i_rst     (i_Reset),
      .i_level   (i_Buttons[i]),
      .i_ms_tick (ms_tick),
      .o_press   (o_Press[i]),
      .o_release (o_Release[i]),
      .o_long    (o_Long[i]),
      .o_repeat  (o_Repeat[i]),
      .o_held    (o_Held[i])
    );
  end

endmodule

// File: doc/button_event_generator.md
Name: button_event_generator

Overview:
- Sits directly downstream of the 4-button debouncer; consumes its registered, clean button levels.
- Converts each level into single-cycle events: press, release, long-press and auto-repeat, plus a held level.
- Game and menu logic consume events instead of raw levels.
- A shared millisecond prescaler times all four buttons.

Parameters:
CLKS_PER_MS, 25000, i_Clk cycles per 1 ms tick (25 MHz board clock)
LONG_PRESS_MS, 800, ms of continuous hold before o_Long fires
REPEAT_PERIOD_MS, 200, ms between o_Repeat pulses after o_Long

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Buttons  in  4  debounced button levels, 1 = pressed, already in i_Clk domain
o_Press  out  4  one-cycle pulse per button on press
o_Release  out  4  one-cycle pulse per button on release
o_Long  out  4  one-cycle pulse when hold reaches LONG_PRESS_MS
o_Repeat  out  4  one-cycle pulse every REPEAT_PERIOD_MS after o_Long while still held
o_Held  out  4  level, 1 while button FSM not IDLE

Behaviour:
- Reset: one clock, i_Clk; reset is asynchronous and active-high (i_Reset).
- Reset values: all outputs 0; prescaler 0; every FSM IDLE; hold counters 0; previous-level registers 0.
- Inputs are not re-synchronised; no combinational input-to-output path.
- Prescaler:
  - Counts 0..CLKS_PER_MS-1 and wraps.
  - ms_tick = 1 for the single cycle where count == CLKS_PER_MS-1.
  - Phase is fixed by reset: first tick on the CLKS_PER_MS-th rising edge after reset release.
- Per-button FSM, states IDLE, PRESSED, HELD:
  - IDLE: input 1 -> PRESSED; hold count cleared; o_Press=1 on the next cycle (latency 1 clock from input rise).
  - PRESSED:
    - input 0 -> IDLE with o_Release pulse.
    - Else on ms_tick the count increments.
    - On the tick where the incremented count == LONG_PRESS_MS -> HELD, o_Long pulse, count cleared.
  - HELD:
    - input 0 -> IDLE with o_Release pulse.
    - Else on ms_tick the count increments.
    - On the tick where it reaches REPEAT_PERIOD_MS -> o_Repeat pulse, count cleared, stay HELD.
  - Any non-IDLE state with input 0 -> IDLE, o_Release pulse, count cleared.
- Simultaneous events:
  - Release in the same cycle as a threshold tick: release wins; no o_Long/o_Repeat pulse.
  - A button already high when reset releases produces o_Press one cycle after the first sampled edge, i.e. it is treated as a fresh press.
- Pulse timing: all pulse outputs registered, exactly one cycle wide; at most one of press/release/long/repeat per button per cycle.
- Hold count: width $clog2(max(LONG_PRESS_MS, REPEAT_PERIOD_MS)+1); it never saturates because it is cleared at each threshold.
- Buttons are fully independent; events on different buttons may coincide in the same cycle.
- Reset mid-hold: FSM returns to IDLE without a release pulse.
- Parameter legality: CLKS_PER_MS >= 2, LONG_PRESS_MS >= 1, REPEAT_PERIOD_MS >= 1; values below these are illegal.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, PRESSED=2'd1, HELD=2'd2) and the default timing constants.
- Sub-module button_event_fsm:
  - One button: level in, ms_tick in; press/release/long/repeat/held out.
  - Parameterised by LONG_PRESS_MS and REPEAT_PERIOD_MS; instantiated 4x.
- Top level holds the shared prescaler.

Test Plan (bench uses CLKS_PER_MS=4, LONG_PRESS_MS=3, REPEAT_PERIOD_MS=2):
- Short tap: raise i_Buttons[0] for 6 cycles -> o_Press[0] for 1 cycle after the rise; o_Release[0] for 1 cycle after the fall; no o_Long; o_Held[0] high 6 cycles.
- Long hold: hold i_Buttons[1] for 30 cycles -> o_Press once, o_Long on the 3rd ms_tick after the press, o_Repeat on every 2nd tick thereafter, o_Release once.
- Release on threshold: drop i_Buttons[2] exactly on the cycle of the 3rd tick -> o_Release[2]=1, o_Long[2]=0.
- Concurrency: press buttons 0 and 3 in the same cycle -> o_Press=4'b1001 in one cycle; independent long timers fire on the same tick.
- Reset mid-hold: assert i_Reset while button 1 is HELD -> all outputs 0 immediately; no o_Release; with the button still high after reset release -> new o_Press[1].
- Reset-high start: i_Buttons=4'b0100 during reset -> o_Press=4'b0100 for one cycle after reset release, then normal hold timing.
